// File: rtl/scan_pkg.sv
// scan_pkg: shared state, width and direction constants for the decoder select scanner
package scan_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int N_CH = 4;
  localparam int SEL_W = 2;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/scan_next_ch.sv
// scan_next_ch: next enabled channel strictly after sel in the travel direction (cyclic), plus last-channel flag
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             dir,
  input  logic [N_CH-1:0]  mask,
  output logic [SEL_W-1:0] nxt,
  output logic             is_last
);
  logic [SEL_W-1:0] c;
  always_comb begin
    nxt = sel;
    is_last = 1'b1;
    c = '0;
    // walk from the farthest offset down so the nearest enabled channel wins
    for (int k = N_CH; k >= 1; k--) begin
      c = (dir == DIR_DN) ? sel - SEL_W'(k) : sel + SEL_W'(k);
      if (mask[c]) nxt = c;
    end
    for (int i = 0; i < N_CH; i++)
      if (mask[i] && ((dir == DIR_DN) ? (i < int'(sel)) : (i > int'(sel)))) is_last = 1'b0;
  end
endmodule

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: dwell-timed channel select scanner for a 2-to-4 decoder; SCAN_MASK_EN adds a channel mask
module decoder_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_MASK_EN
  input  logic [N_CH-1:0]    mask,
`endif
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               step,
  output logic               busy,
  output logic               done
);
  state_e             state;
  logic               run, dir_r, cont_r, is_last;
  logic [DWELL_W-1:0] dwell_r, cnt;
  logic [N_CH-1:0]    en_in, mask_r;
  logic [SEL_W-1:0]   first_from, nxt;
`ifdef SCAN_MASK_EN
  assign en_in = mask;
`else
  assign en_in = '1;
`endif
  assign run = state == RUN;
  assign busy = run;
  assign sel_valid = run;
  // in IDLE the finder searches from just before the first channel, yielding the start channel
  assign first_from = (dir == DIR_DN) ? '0 : '1;
  scan_next_ch u_next (
    .sel     (run ? sel : first_from),
    .dir     (run ? dir_r : dir),
    .mask    (run ? mask_r : en_in),
    .nxt     (nxt),
    .is_last (is_last)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      step <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      dwell_r <= '0;
      dir_r <= DIR_UP;
      cont_r <= 1'b0;
      mask_r <= '0;
    end else begin
      step <= 1'b0;
      done <= 1'b0;
      if (!run) begin
        if (start && !stop && |en_in) begin
          state <= RUN;
          dir_r <= dir;
          cont_r <= continuous;
          dwell_r <= dwell;
          mask_r <= en_in;
          sel <= nxt;
          cnt <= dwell;
        end
      end else if (stop) begin
        state <= IDLE;
        sel <= '0;
      end else if (cnt != '0) begin
        cnt <= cnt - DWELL_W'(1);
      end else if (is_last && !cont_r) begin
        state <= IDLE;
        done <= 1'b1;
        sel <= '0;
      end else begin
        sel <= nxt;
        cnt <= dwell_r;
        step <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: randomized scoreboard bench for decoder_scan_ctrl (mask scans only with SCAN_MASK_EN)
module tb_decoder_scan_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, continuous = 1'b0, dir = 1'b0;
  logic [7:0] dwell = '0;
  logic [3:0] mask = 4'hf;
  logic [1:0] sel;
  logic       sel_valid, step, busy, done;
  typedef struct packed {logic v; logic b; logic [1:0] s; logic st; logic dn;} rec_t;
  rec_t q[$];
  int   compared = 0, mismatched = 0;
  bit   mon_en = 1'b0;

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .dir        (dir),
    .dwell      (dwell),
`ifdef SCAN_MASK_EN
    .mask       (mask),
`endif
    .sel        (sel),
    .sel_valid  (sel_valid),
    .step       (step),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rec_t got, exp;
    if (mon_en) begin
      got = {sel_valid, busy, sel, step, done};
      if (sel_valid | busy | step | done) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_output: got v=%b b=%b sel=%0d step=%b done=%b with nothing expected",
                   got.v, got.b, got.s, got.st, got.dn);
        end else begin
          exp = q.pop_front();
          if (got !== exp) begin
            mismatched++;
            $display("FAIL scan_cycle: got v=%b b=%b sel=%0d step=%b done=%b expected v=%b b=%b sel=%0d step=%b done=%b",
                     got.v, got.b, got.s, got.st, got.dn, exp.v, exp.b, exp.s, exp.st, exp.dn);
          end
        end
      end else begin
        compared++;
        if (sel !== 2'd0) begin
          mismatched++;
          $display("FAIL idle_sel: got %0d expected 0", sel);
        end
      end
    end
  end

  function automatic int popc(input logic [3:0] m);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(m[i]);
    return n;
  endfunction

  // model: the scan visits the enabled channels in travel order, each for dwell+1 cycles
  task automatic run_scan(input logic d_i, input logic c_i, input logic [7:0] dw, input logic [3:0] m_i,
                          input int stop_at, input bit use_rst);
    logic [3:0] m;
    int lst[$];
    int L, hold, total;
    m = m_i;
`ifndef SCAN_MASK_EN
    m = 4'hf;
`endif
    for (int i = 0; i < 4; i++) begin
      int ch;
      ch = d_i ? 3 - i : i;
      if (m[ch]) lst.push_back(ch);
    end
    L = lst.size();
    hold = int'(dw) + 1;
    total = (L == 0) ? 0 : (stop_at > 0 ? stop_at : L * hold);
    @(negedge clk);
    dir = d_i; continuous = c_i; dwell = dw; mask = m_i; start = 1'b1; stop = 1'b0;
    for (int j = 1; j <= total; j++)
      q.push_back({1'b1, 1'b1, 2'(lst[((j - 1) / hold) % L]), (j > 1 && (j - 1) % hold == 0), 1'b0});
    if (L > 0 && stop_at == 0) q.push_back(6'b000001);
    for (int k = 1; k < total; k++) begin
      @(negedge clk);
      start = 1'($urandom); dir = 1'($urandom); continuous = 1'($urandom);
      dwell = 8'($urandom); mask = 4'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    if (stop_at > 0 && L > 0) begin
      if (use_rst) rst_n = 1'b0;
      else stop = 1'b1;
    end
    @(negedge clk);
    stop = 1'b0;
    if (use_rst) begin
      check("rst_sel", 32'(sel), 0);
      check("rst_sel_valid", 32'(sel_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_step", 32'(step), 0);
      check("rst_done", 32'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 0);
  endtask

  initial begin
    logic d, c;
    logic [7:0] dw;
    logic [3:0] m;
    int L, sa;
    repeat (2) @(negedge clk);
    check("reset_sel", 32'(sel), 0);
    check("reset_sel_valid", 32'(sel_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_step", 32'(step), 0);
    check("reset_done", 32'(done), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_scan(1'b0, 1'b0, 8'd2, 4'hf, 0, 1'b0);
    run_scan(1'b1, 1'b1, 8'd0, 4'hf, 10, 1'b0);
    run_scan(1'b0, 1'b0, 8'd3, 4'hf, 5, 1'b0);
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", 32'(busy), 0);
    run_scan(1'b0, 1'b1, 8'd1, 4'hf, 6, 1'b1);
    run_scan(1'b1, 1'b0, 8'd255, 4'hf, 0, 1'b0);
`ifdef SCAN_MASK_EN
    run_scan(1'b0, 1'b0, 8'd1, 4'b1010, 0, 1'b0);
    run_scan(1'b0, 1'b0, 8'd1, 4'b0000, 0, 1'b0);
    check("empty_mask_busy", 32'(busy), 0);
`endif
    for (int n = 0; n < 30; n++) begin
      d = 1'($urandom); c = 1'($urandom);
      dw = 8'($urandom_range(0, 4));
`ifdef SCAN_MASK_EN
      m = 4'($urandom);
`else
      m = 4'hf;
`endif
      L = popc(m) * (int'(dw) + 1);
      if (c) sa = $urandom_range(1, 25);
      else sa = (L > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, L - 1) : 0;
      run_scan(d, c, dw, m, sa, ($urandom_range(0, 3) == 0) && sa > 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
